ram_access_ctrl: RTL and testbench
==================================

RAM_ACCESS_CTRL -- requirements
Module: ram_access_ctrl

Interface
REQ-001 Parameters SHALL be WORD_SIZE, default 20, data word width; and WORD_AMOUNT, default 30, number of RAM words.
REQ-002 AW SHALL equal $clog2(WORD_AMOUNT)+1 for all address ports.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  controller can accept a request.
REQ-007 req_op  in  1  operation: 0 = READ, 1 = WRITE.
REQ-008 req_addr  in  AW  word address.
REQ-009 req_wdata  in  WORD_SIZE  write data.
REQ-010 resp_valid  out  1  response present.
REQ-011 resp_ready  in  1  consumer accepts the response.
REQ-012 resp_rdata  out  WORD_SIZE  read data; 0 for writes and errors.
REQ-013 resp_err  out  1  request rejected.
REQ-014 ram_address  out  AW  address to the RAM.
REQ-015 ram_select  out  1  access strobe; the RAM acts on its rising edge.
REQ-016 ram_operation  out  1  operation to the RAM.
REQ-017 ram_wdata  out  WORD_SIZE  write data to the RAM.
REQ-018 ram_rdata  in  WORD_SIZE  read data from the RAM.

Function
REQ-019 FSM states SHALL be IDLE, SETUP, STROBE, CAPTURE and RESP.
REQ-020 All outputs SHALL be registered; req_ready SHALL be 1 only in IDLE.
REQ-021 IDLE, on req_valid: latch op, addr and wdata onto the ram_* outputs, with ram_select=0, then go to SETUP.
REQ-022 SETUP -> STROBE unconditionally; ram_select=1 throughout STROBE; ram_address, ram_operation and ram_wdata stable from SETUP through CAPTURE.
REQ-023 STROBE -> CAPTURE; ram_select=0 in CAPTURE.
REQ-024 CAPTURE -> RESP: resp_rdata <= ram_rdata for READ, 0 for WRITE; resp_err <= 0.
REQ-025 RESP SHALL hold resp_valid=1 with resp_rdata and resp_err stable until resp_ready=1, then clear resp_valid and go to IDLE.
REQ-026 Latency: resp_valid SHALL rise exactly 3 cycles after the accept edge; with resp_ready tied 1, back-to-back throughput SHALL be 1 request per 5 cycles.
REQ-027 Exactly one rising edge of ram_select per accepted non-error request; none otherwise.
REQ-028 Requests presented while req_ready=0 SHALL be ignored, not queued.

Reset
REQ-029 On rst: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, ram_select=0, ram_address=0, ram_operation=0, ram_wdata=0.
REQ-030 rst asserted mid-transaction SHALL abort it with no response; if the strobe edge was already issued, the RAM-side effect stands.
REQ-031 rst SHALL take priority over every other input in the same cycle.

Configuration
REQ-032 With macro RAM_CTRL_BOUNDS_EN defined, a request with req_addr >= WORD_AMOUNT SHALL go IDLE -> RESP directly, with resp_err=1, resp_rdata=0 and no ram_select pulse; resp_valid rises 1 cycle after accept.
REQ-033 Without RAM_CTRL_BOUNDS_EN, resp_err SHALL be constant 0 and every address SHALL be forwarded to the RAM.

Structure
REQ-034 Shared package ram_pkg SHALL hold the READ=0 and WRITE=1 operation constants and the FSM state enum type.
REQ-035 No sub-module; the RAM is instantiated beside this block at the enclosing level.

Verification
REQ-036 Write then read: WRITE addr 5, data 0x3A5C1 -> one select pulse; resp_err=0. READ addr 5 -> resp_rdata=0x3A5C1 exactly 3 cycles after accept.
REQ-037 Backpressure: READ addr 0 with resp_ready=0 for 6 cycles -> resp_valid and resp_rdata stable, req_ready=0, a second req_valid is ignored; resp_ready=1 -> IDLE next cycle.
REQ-038 Bounds: with RAM_CTRL_BOUNDS_EN, WRITE addr 30 -> resp_err=1 one cycle after accept, no select edge, and a subsequent read of addr 29 returns its old value. Without the macro, the same request -> resp_err=0 and one select pulse.
REQ-039 Reset in STROBE: rst asserted while ram_select=1 -> next cycle ram_select=0, resp_valid=0, req_ready=1; no response is ever issued.
REQ-040 Streaming: 8 sequential writes to addrs 0..7 with resp_ready=1 -> 40 cycles total, 8 select pulses; read-back of all 8 matches.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared definitions for the RAM access controller: operation codes and FSM state type.
package ram_pkg;

    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        CAPTURE,
        RESP
    } state_t;

endpackage

// File: rtl/ram_access_ctrl.sv
// Request/response front end that sequences one strobed access to an external RAM per request.
// Optional address bounds checking is enabled by defining RAM_CTRL_BOUNDS_EN.
module ram_access_ctrl
    import ram_pkg::*;
#(
    parameter int WORD_SIZE   = 20,
    parameter int WORD_AMOUNT = 30,
    localparam int AW         = $clog2(WORD_AMOUNT) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_op,
    input  logic [AW-1:0]        req_addr,
    input  logic [WORD_SIZE-1:0] req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [WORD_SIZE-1:0] resp_rdata,
    output logic                 resp_err,
    output logic [AW-1:0]        ram_address,
    output logic                 ram_select,
    output logic                 ram_operation,
    output logic [WORD_SIZE-1:0] ram_wdata,
    input  logic [WORD_SIZE-1:0] ram_rdata
);

    state_t                 state_q, state_d;
    logic                   req_ready_d;
    logic                   resp_valid_d;
    logic [WORD_SIZE-1:0]   resp_rdata_d;
    logic                   resp_err_d;
    logic [AW-1:0]          ram_address_d;
    logic                   ram_select_d;
    logic                   ram_operation_d;
    logic [WORD_SIZE-1:0]   ram_wdata_d;

    // Every output is computed one cycle ahead so it can leave the block straight from a flop.
    always_comb begin
        state_d         = state_q;
        req_ready_d     = req_ready;
        resp_valid_d    = resp_valid;
        resp_rdata_d    = resp_rdata;
        resp_err_d      = resp_err;
        ram_address_d   = ram_address;
        ram_select_d    = 1'b0;
        ram_operation_d = ram_operation;
        ram_wdata_d     = ram_wdata;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_ready_d = 1'b0;
`ifdef RAM_CTRL_BOUNDS_EN
                    // Out-of-range requests never touch the RAM; the response is raised one cycle later in RESP.
                    if (req_addr >= AW'(WORD_AMOUNT)) begin
                        state_d      = RESP;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else
`endif
                    begin
                        state_d         = SETUP;
                        ram_address_d   = req_addr;
                        ram_operation_d = req_op;
                        ram_wdata_d     = req_wdata;
                    end
                end
            end
            SETUP: begin
                state_d      = STROBE;
                ram_select_d = 1'b1;
            end
            STROBE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = (ram_operation == READ) ? ram_rdata : '0;
            end
            RESP: begin
                if (!resp_valid) begin
                    resp_valid_d = 1'b1;
                end else if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_err      <= 1'b0;
            ram_address   <= '0;
            ram_select    <= 1'b0;
            ram_operation <= 1'b0;
            ram_wdata     <= '0;
        end else begin
            state_q       <= state_d;
            req_ready     <= req_ready_d;
            resp_valid    <= resp_valid_d;
            resp_rdata    <= resp_rdata_d;
            resp_err      <= resp_err_d;
            ram_address   <= ram_address_d;
            ram_select    <= ram_select_d;
            ram_operation <= ram_operation_d;
            ram_wdata     <= ram_wdata_d;
        end
    end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench for ram_access_ctrl: a behavioural RAM beside the DUT plus a
// last-written-value memory model; builds with or without RAM_CTRL_BOUNDS_EN.
module tb_ram_access_ctrl;
    import ram_pkg::*;

    localparam int WS = 20;
    localparam int WA = 30;
    localparam int AW = $clog2(WA) + 1;
`ifdef RAM_CTRL_BOUNDS_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_op;
    logic [AW-1:0] req_addr;
    logic [WS-1:0] req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [WS-1:0] resp_rdata;
    logic          resp_err;
    logic [AW-1:0] ram_address;
    logic          ram_select;
    logic          ram_operation;
    logic [WS-1:0] ram_wdata;
    logic [WS-1:0] ram_rdata;

    logic [WS-1:0] ramMem [0:63];
    logic [WS-1:0] refMem [0:63];
    int            pulseCount = 0;
    int            cycleCount = 0;
    int            checkCount = 0;
    int            passCount  = 0;

    ram_access_ctrl #(.WORD_SIZE(WS), .WORD_AMOUNT(WA)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ram_address(ram_address), .ram_select(ram_select),
        .ram_operation(ram_operation), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // The RAM acts only on the rising edge of its select strobe.
    always @(posedge ram_select) begin
        pulseCount <= pulseCount + 1;
        if (ram_operation == WRITE) ramMem[ram_address] <= ram_wdata;
        else                        ram_rdata <= ramMem[ram_address];
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    endtask

    // One complete transaction, starting and ending on a falling edge.
    task automatic applyStimulus(input logic op, input logic [AW-1:0] addr,
                                 input logic [WS-1:0] wdata, input int holdCycles);
        logic          isErr;
        logic [WS-1:0] expData;
        int            lat;
        int            pulsesBefore;
        isErr   = BOUNDS && (int'(addr) >= WA);
        expData = (!isErr && op == READ) ? refMem[addr] : '0;
        if (!isErr && op == WRITE) refMem[addr] = wdata;
        checkOutput("idle_req_ready", {31'd0, req_ready}, 32'd1);
        pulsesBefore = pulseCount;
        req_valid  = 1'b1;
        req_op     = op;
        req_addr   = addr;
        req_wdata  = wdata;
        resp_ready = (holdCycles == 0);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("latency", 32'(lat), isErr ? 32'd1 : 32'd3);
        checkOutput("resp_rdata", 32'(resp_rdata), 32'(expData));
        checkOutput("resp_err", {31'd0, resp_err}, {31'd0, isErr});
        for (int i = 0; i < holdCycles; i++) begin
            if (i == 0) begin
                req_valid = 1'b1;
                req_op    = WRITE;
                req_addr  = addr ^ 6'd1;
                req_wdata = ~wdata;
            end
            @(negedge clk);
            req_valid = 1'b0;
            checkOutput("hold_valid", {31'd0, resp_valid}, 32'd1);
            checkOutput("hold_rdata", 32'(resp_rdata), 32'(expData));
            checkOutput("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        checkOutput("done_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("done_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("pulse_count", 32'(pulseCount - pulsesBefore), isErr ? 32'd0 : 32'd1);
    endtask

    initial begin
        int            c0;
        int            waitCnt;
        int            p0;
        logic          sawResp;
        logic [WS-1:0] d;
        for (int i = 0; i < 64; i++) begin
            d = WS'($urandom);
            ramMem[i] = d;
            refMem[i] = d;
        end
        ram_rdata  = '0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_op     = READ;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("rst_resp_err", {31'd0, resp_err}, 32'd0);
        checkOutput("rst_resp_rdata", 32'(resp_rdata), 32'd0);
        checkOutput("rst_ram_select", {31'd0, ram_select}, 32'd0);
        checkOutput("rst_ram_address", 32'(ram_address), 32'd0);
        checkOutput("rst_ram_operation", {31'd0, ram_operation}, 32'd0);
        checkOutput("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] write then read address 5");
        applyStimulus(WRITE, 6'd5, 20'h3A5C1, 0);
        applyStimulus(READ, 6'd5, 20'h0, 0);
        checkOutput("readback_5", 32'(refMem[5]), 32'h3A5C1);

        $display("[TB] backpressure on read of address 0");
        applyStimulus(READ, 6'd0, 20'h0, 6);

        $display("[TB] boundary addresses 29 and 30");
        applyStimulus(READ, 6'd29, 20'h0, 0);
        applyStimulus(WRITE, 6'd30, 20'h12345, 1);
        applyStimulus(READ, 6'd29, 20'h0, 0);
        applyStimulus(READ, 6'd30, 20'h0, 0);

        $display("[TB] reset while strobe is high");
        p0 = pulseCount;
        req_valid = 1'b1;
        req_op    = WRITE;
        req_addr  = 6'd10;
        req_wdata = 20'hABCDE;
        resp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        waitCnt = 0;
        while (!ram_select && waitCnt < 10) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("strobe_seen", {31'd0, ram_select}, 32'd1);
        refMem[10] = 20'hABCDE;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_select", {31'd0, ram_select}, 32'd0);
        checkOutput("abort_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("abort_req_ready", {31'd0, req_ready}, 32'd1);
        sawResp = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) sawResp = 1'b1;
        end
        checkOutput("abort_no_resp", {31'd0, sawResp}, 32'd0);
        checkOutput("abort_pulses", 32'(pulseCount - p0), 32'd1);
        applyStimulus(READ, 6'd10, 20'h0, 0);

        $display("[TB] randomized transactions");
        for (int n = 0; n < 24; n++) begin
            applyStimulus(1'($urandom), AW'($urandom_range(31, 0)), WS'($urandom),
                          int'($urandom_range(3, 0)));
        end

        $display("[TB] streaming writes to addresses 0..7");
        c0 = cycleCount;
        p0 = pulseCount;
        for (int i = 0; i < 8; i++) applyStimulus(WRITE, AW'(i), WS'($urandom), 0);
        checkOutput("stream_cycles", 32'(cycleCount - c0), 32'd40);
        checkOutput("stream_pulses", 32'(pulseCount - p0), 32'd8);
        for (int i = 0; i < 8; i++) applyStimulus(READ, AW'(i), 20'h0, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
